// File: rtl/field_serializer.sv
// Captures a frame of N entries (x/y/z fields each W bits) and streams it out one field per
// handshake, index-major then field, with a one-cycle frame_done pulse after the last word.
module field_serializer #(
    parameter int N = 2,
    parameter int W = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [N*W-1:0]                       in_x,
    input  logic [N*W-1:0]                       in_y,
    input  logic [N*W-1:0]                       in_z,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [W-1:0]                         out_data,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_index,
    output logic [1:0]                           out_field,
    output logic                                 out_last,
    output logic                                 frame_done
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {StIdle, StSend} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [1:0]    fld_q, fld_d;
    logic          done_q, done_d;
    logic          capture;
    logic          last_word;
    logic [W-1:0]  data_sel;

    logic [W-1:0] cap_x [N];
    logic [W-1:0] cap_y [N];
    logic [W-1:0] cap_z [N];

    assign last_word = (state_q == StSend) && (idx_q == IW'(N - 1)) && (fld_q == 2'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            fld_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fld_q   <= fld_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        fld_d   = fld_q;
        done_d  = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    fld_d   = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (out_ready) begin
                    if (last_word) begin
                        // Counters return to zero so the idle outputs read as (0,x).
                        state_d = StIdle;
                        idx_d   = '0;
                        fld_d   = '0;
                        done_d  = 1'b1;
                    end else if (fld_q == 2'd2) begin
                        fld_d = '0;
                        idx_d = idx_q + IW'(1);
                    end else begin
                        fld_d = fld_q + 2'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                cap_x[i] <= '0;
                cap_y[i] <= '0;
                cap_z[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < N; i++) begin
                cap_x[i] <= in_x[i*W +: W];
                cap_y[i] <= in_y[i*W +: W];
                cap_z[i] <= in_z[i*W +: W];
            end
        end
    end

    // Compare-based select keeps out-of-range indices (non power-of-two N) harmless.
    always_comb begin
        data_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IW'(i)) begin
                case (fld_q)
                    2'd0:    data_sel = cap_x[i];
                    2'd1:    data_sel = cap_y[i];
                    2'd2:    data_sel = cap_z[i];
                    default: data_sel = '0;
                endcase
            end
        end
    end

    always_comb begin
        in_ready   = (state_q == StIdle);
        out_valid  = (state_q == StSend);
        out_data   = out_valid ? data_sel : '0;
        out_index  = idx_q;
        out_field  = fld_q;
        out_last   = last_word;
        frame_done = done_q;
    end

endmodule

// File: tb/tb_field_serializer.sv
// Scoreboard bench for field_serializer: three instances (N=2/W=8, N=1/W=4, N=3/W=8) with
// directed frames; expected words are queued at issue time and checked by negedge monitors.
module tb_field_serializer;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] idx;
        logic [1:0] fld;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: N=2, W=8
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_frame_done;
    logic [15:0] a_x, a_y, a_z;
    logic [7:0]  a_out_data;
    logic [0:0]  a_out_index;
    logic [1:0]  a_out_field;

    // Instance B: N=1, W=4
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_frame_done;
    logic [3:0]  b_x, b_y, b_z, b_out_data;
    logic [0:0]  b_out_index;
    logic [1:0]  b_out_field;

    // Instance C: N=3, W=8
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last, c_frame_done;
    logic [23:0] c_x, c_y, c_z;
    logic [7:0]  c_out_data;
    logic [1:0]  c_out_index;
    logic [1:0]  c_out_field;

    field_serializer #(.N(2), .W(8)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_x(a_x), .in_y(a_y), .in_z(a_z), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_index(a_out_index), .out_field(a_out_field),
        .out_last(a_out_last), .frame_done(a_frame_done)
    );

    field_serializer #(.N(1), .W(4)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_x(b_x), .in_y(b_y), .in_z(b_z), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_index(b_out_index), .out_field(b_out_field),
        .out_last(b_out_last), .frame_done(b_frame_done)
    );

    field_serializer #(.N(3), .W(8)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_x(c_x), .in_y(c_y), .in_z(c_z), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .out_index(c_out_index), .out_field(c_out_field),
        .out_last(c_out_last), .frame_done(c_frame_done)
    );

    int total = 0;
    int bad   = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic [3:0] i, input logic [1:0] f,
                                input logic l);
        exp_t e;
        e.data = d;
        e.idx  = i;
        e.fld  = f;
        e.last = l;
        return e;
    endfunction

    function automatic int qsize(input int which);
        if (which == 0) return qa.size();
        if (which == 1) return qb.size();
        return qc.size();
    endfunction

    // Monitor A: scoreboard pops, hold stability, frame_done timing, in_ready exclusivity.
    logic a_exp_fd = 1'b0;
    logic a_hold   = 1'b0;
    exp_t a_held;
    int   a_stall_cnt = 0;
    always @(negedge clk) begin
        exp_t cur, e;
        if (rst) begin
            qa.delete();
            a_exp_fd = 1'b0;
            a_hold   = 1'b0;
        end else begin
            chk("a_frame_done", a_frame_done, a_exp_fd);
            chk("a_in_ready", a_in_ready, !a_out_valid);
            a_exp_fd = 1'b0;
            cur = mk(a_out_data, a_out_index, a_out_field, a_out_last);
            if (a_hold) chk("a_hold_stable", cur, a_held);
            a_hold = 1'b0;
            if (a_out_valid) begin
                if (a_out_ready) begin
                    if (qa.size() == 0) begin
                        chk("a_unexpected_word", qa.size(), 1);
                    end else begin
                        e = qa.pop_front();
                        chk("a_word", cur, e);
                        a_exp_fd = e.last;
                    end
                end else begin
                    a_hold = 1'b1;
                    a_held = cur;
                    a_stall_cnt++;
                end
            end
        end
    end

    logic b_exp_fd = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            qb.delete();
            b_exp_fd = 1'b0;
        end else begin
            chk("b_frame_done", b_frame_done, b_exp_fd);
            b_exp_fd = 1'b0;
            if (b_out_valid && b_out_ready) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_word", qb.size(), 1);
                end else begin
                    e = qb.pop_front();
                    chk("b_word", mk(b_out_data, b_out_index, b_out_field, b_out_last), e);
                    b_exp_fd = e.last;
                end
            end
        end
    end

    logic c_exp_fd = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            qc.delete();
            c_exp_fd = 1'b0;
        end else begin
            chk("c_frame_done", c_frame_done, c_exp_fd);
            c_exp_fd = 1'b0;
            if (c_out_valid && c_out_ready) begin
                chk("c_index_range", c_out_index < 2'd3, 1);
                if (qc.size() == 0) begin
                    chk("c_unexpected_word", qc.size(), 1);
                end else begin
                    e = qc.pop_front();
                    chk("c_word", mk(c_out_data, c_out_index, c_out_field, c_out_last), e);
                    c_exp_fd = e.last;
                end
            end
        end
    end

    task automatic push_a(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        for (int i = 0; i < 2; i++) begin
            qa.push_back(mk(x[i*8 +: 8], 4'(i), 2'd0, 1'b0));
            qa.push_back(mk(y[i*8 +: 8], 4'(i), 2'd1, 1'b0));
            qa.push_back(mk(z[i*8 +: 8], 4'(i), 2'd2, i == 1));
        end
    endtask

    // Drives a frame into A and returns 2 time units after the capturing edge.
    task automatic send_a(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                          input logic keep_valid);
        logic rdy;
        int   k;
        push_a(x, y, z);
        @(posedge clk);
        #2;
        a_x = x;
        a_y = y;
        a_z = z;
        a_in_valid = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            rdy = a_in_ready;
            @(posedge clk);
            k++;
        end while (!rdy && k < 50);
        chk("a_capture_ready", rdy, 1);
        #2;
        if (!keep_valid) a_in_valid = 1'b0;
    endtask

    task automatic wait_empty(input int which, input int budget, input string name);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (qsize(which) == 0) break;
        end
        chk(name, qsize(which), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        a_in_valid = 1'b0; a_out_ready = 1'b1; a_x = '0; a_y = '0; a_z = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_x = '0; b_y = '0; b_z = '0;
        c_in_valid = 1'b0; c_out_ready = 1'b1; c_x = '0; c_y = '0; c_z = '0;

        #1;
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_out_index", a_out_index, 0);
        chk("rst_out_field", a_out_field, 0);
        chk("rst_out_last", a_out_last, 0);
        chk("rst_frame_done", a_frame_done, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Basic frame, out_ready=1: 6 consecutive words, done one cycle after the last.
        send_a(16'h1110, 16'h2120, 16'h3130, 1'b0);
        @(negedge clk);
        chk("t1_latency_valid", a_out_valid, 1);
        chk("t1_first_data", a_out_data, 8'h10);
        repeat (5) @(negedge clk);
        #1;
        chk("t1_six_words", qa.size(), 0);
        @(negedge clk);
        chk("t1_done_timing", a_frame_done, 1);

        // Backpressure on SEND cycles 2-4: (0,y) held three cycles.
        a_stall_cnt = 0;
        send_a(16'h1110, 16'h2120, 16'h3130, 1'b0);
        @(posedge clk);
        #2 a_out_ready = 1'b0;
        @(negedge clk);
        chk("t2_held_word", a_out_data, 8'h20);
        repeat (3) @(posedge clk);
        #2 a_out_ready = 1'b1;
        wait_empty(0, 20, "t2_drain");
        chk("t2_stall_cycles", a_stall_cnt, 3);
        repeat (2) @(negedge clk);

        // in_valid held high: live inputs change mid-SEND, second frame captured right after.
        send_a(16'h0201, 16'h0403, 16'h0605, 1'b1);
        a_x = 16'hE1E0; a_y = 16'hF1F0; a_z = 16'hD1D0;
        push_a(16'hE1E0, 16'hF1F0, 16'hD1D0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (a_frame_done) break;
        end
        chk("t3_done_seen", a_frame_done, 1);
        chk("t3_ready_at_done", a_in_ready, 1);
        @(posedge clk);
        #2 a_in_valid = 1'b0;
        @(negedge clk);
        chk("t3_b2b_valid", a_out_valid, 1);
        chk("t3_b2b_index", a_out_index, 0);
        chk("t3_b2b_field", a_out_field, 0);
        wait_empty(0, 20, "t3_drain");
        repeat (2) @(negedge clk);

        // Reset after the third word handshake, then a fresh frame.
        send_a(16'hA1A0, 16'hB1B0, 16'hC1C0, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t4_async_valid", a_out_valid, 0);
        chk("t4_async_ready", a_in_ready, 1);
        chk("t4_async_data", a_out_data, 0);
        chk("t4_async_index", a_out_index, 0);
        chk("t4_async_field", a_out_field, 0);
        chk("t4_async_last", a_out_last, 0);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        send_a(16'h4544, 16'h5554, 16'h6564, 1'b0);
        @(negedge clk);
        chk("t4_restart_data", a_out_data, 8'h44);
        wait_empty(0, 20, "t4_drain");

        // N=1, W=4
        qb.push_back(mk(8'h3, 4'd0, 2'd0, 1'b0));
        qb.push_back(mk(8'h7, 4'd0, 2'd1, 1'b0));
        qb.push_back(mk(8'hA, 4'd0, 2'd2, 1'b1));
        @(posedge clk);
        #2;
        b_x = 4'h3; b_y = 4'h7; b_z = 4'hA;
        b_in_valid = 1'b1;
        @(posedge clk);
        #2 b_in_valid = 1'b0;
        wait_empty(1, 20, "t5_drain");

        // N=3: index sequence 0,0,0,1,1,1,2,2,2
        c_x = 24'h121110; c_y = 24'h222120; c_z = 24'h323130;
        for (int i = 0; i < 3; i++) begin
            qc.push_back(mk(c_x[i*8 +: 8], 4'(i), 2'd0, 1'b0));
            qc.push_back(mk(c_y[i*8 +: 8], 4'(i), 2'd1, 1'b0));
            qc.push_back(mk(c_z[i*8 +: 8], 4'(i), 2'd2, i == 2));
        end
        @(posedge clk);
        #2 c_in_valid = 1'b1;
        @(posedge clk);
        #2 c_in_valid = 1'b0;
        wait_empty(2, 30, "t6_drain");

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/field_serializer.md
FIELD_SERIALIZER -- requirements
Module: field_serializer

Interface
REQ-001 The block SHALL have parameter N, default 2, giving the number of indexed entries per frame, with legal values 1..16.
REQ-002 The block SHALL have parameter W, default 8, giving the width of each x/y/z field in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream frame is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a frame.
REQ-007 The block SHALL have port in_x, input, N*W bits: entry i x-field in bits [i*W +: W].
REQ-008 The block SHALL have port in_y, input, N*W bits: entry i y-field, packed like in_x.
REQ-009 The block SHALL have port in_z, input, N*W bits: entry i z-field, packed like in_x.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the downstream stage accepts the word.
REQ-012 The block SHALL have port out_data, output, W bits: the current field value.
REQ-013 The block SHALL have port out_index, output, max(1,$clog2(N)) bits: the entry index of the current word.
REQ-014 The block SHALL have port out_field, output, 2 bits: the field selector, 0=x, 1=y, 2=z; 3 is never driven.
REQ-015 The block SHALL have port out_last, output, 1 bit: high on the final word of a frame (index N-1, field z).
REQ-016 The block SHALL have port frame_done, output, 1 bit: a one-cycle pulse after the final word handshake.

Function
REQ-017 The block SHALL implement a two-state FSM with states IDLE and SEND.
REQ-018 In IDLE, in_ready SHALL be 1, out_valid SHALL be 0, and the block SHALL not drive in_ready combinationally from out_ready.
REQ-019 On an in_valid && in_ready edge, the block SHALL register all of in_x, in_y and in_z, set the index to 0 and the field to 0, and enter SEND.
REQ-020 In SEND, in_ready SHALL be 0 and out_valid SHALL be 1; the first word SHALL appear in the cycle after capture, giving 1 cycle of latency.
REQ-021 The word order SHALL be index-major then field: (0,x),(0,y),(0,z),(1,x)…(N-1,z), which is 3*N words per frame.
REQ-022 out_data SHALL equal the captured field selected by out_index and out_field, taken from registers and never from live in_* inputs.
REQ-023 On out_valid && out_ready, the field SHALL advance; when it wraps from z to x, the index SHALL increment.
REQ-024 While out_ready=0, out_data, out_index, out_field and out_last SHALL remain stable, with no word dropped or duplicated.
REQ-025 On the handshake of the out_last word, the FSM SHALL return to IDLE, in_ready SHALL rise in the next cycle, and frame_done SHALL pulse for exactly that cycle.
REQ-026 A new frame SHALL NOT be accepted in the same cycle as the final handshake, so the minimum frame period is 3*N+1 cycles.
REQ-027 Changes on in_* during SEND SHALL be ignored.
REQ-028 For N=1, the index SHALL stay 0 and out_last SHALL be high on (0,z).
REQ-029 The index counter SHALL never exceed N-1, including when N is not a power of two.

Reset
REQ-030 Asserting rst SHALL immediately force IDLE, index 0, field 0, out_valid=0, out_last=0, frame_done=0, in_ready=1, out_data=0, out_index=0 and out_field=0.
REQ-031 If rst asserts mid-frame, the partial frame SHALL be discarded, and after release the next accepted frame SHALL start at (0,x).
REQ-032 Captured data registers SHALL reset to 0.

Verification
REQ-033 N=2, W=8, out_ready=1: capture x={0x11,0x10}, y={0x21,0x20}, z={0x31,0x30} (entry1,entry0) -> the block emits 0x10,0x20,0x30,0x11,0x21,0x31 on consecutive cycles starting 1 cycle after capture, out_last on the 6th word, and frame_done one cycle later.
REQ-034 The same frame with out_ready low on cycles 2-4 of SEND -> word (0,y)=0x20 is held stable for 3 cycles, and the sequence and count are unchanged.
REQ-035 in_valid held high continuously -> the second frame is captured exactly 1 cycle after the final handshake, and in_ready is 0 throughout SEND.
REQ-036 rst pulsed after the 3rd word handshake -> outputs are at reset values asynchronously, and the next frame starts at (0,x) with new data.
REQ-037 N=1, W=4, z=0xA -> 3 words are emitted, and out_last=1 with out_data=0xA on the 3rd word.
REQ-038 N=3 -> out_index sequence 0,0,0,1,1,1,2,2,2, and the index never reaches 3.
